load_writeback_unit: RTL
========================

Name: load_writeback_unit

Overview:
- Multicycle load engine for the MIPS core: fetches a data word over the Avalon-MM master read port, then aligns, extends and merges it per load opcode.
- Acts as the producer (writer side) for the register file write port: drives write_reg, write_data and reg_write as a single-cycle write strobe.
- Sits between the EXECUTE/MEMORY_ACCESS control and the register file; the control FSM issues start and waits for done.

Parameters:
- TIMEOUT_CYCLES, 255: waitrequest cycles tolerated before abort; used only with LOAD_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- instr  in  32  load instruction; opcode = [31:26], rt = [20:16]
- addr  in  32  effective byte address (rs + offset)
- rt_old  in  32  current rt value, for LWL/LWR merge
- avm_address  out  32  word address {addr[31:2], 2'b00}
- avm_read  out  1  Avalon read request
- avm_byteenable  out  4  always 4'b1111 while avm_read = 1, else 0
- avm_readdata  in  32  read data, little-endian
- avm_waitrequest  in  1  stall; data valid in any cycle with avm_read=1 and waitrequest=0
- reg_write  out  1  one-cycle register write strobe
- write_reg  out  5  destination register
- write_data  out  32  merged result
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = aborted, no write performed

Behaviour:
- Reset: state IDLE. All outputs 0. Internal instr, addr and rt_old latches cleared.
- Supported opcodes: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110.
- FSM: IDLE -> REQ -> WRITE -> IDLE, plus a FAULT state.
- IDLE:
  - On start: latch instr, addr and rt_old.
  - Unsupported opcode -> FAULT.
  - Misaligned address -> FAULT. Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - Otherwise -> REQ.
  - start outside IDLE is ignored.
- REQ:
  - avm_read = 1, with avm_address and avm_byteenable held stable.
  - On a cycle with waitrequest=0: capture readdata -> WRITE.
  - waitrequest=1: remain in REQ with all outputs unchanged.
- WRITE (one cycle):
  - done = 1, err = 0.
  - reg_write = 1 unless rt == 0; rt == 0 suppresses the write, done still pulses.
  - write_reg = rt; write_data per the alignment rules below -> IDLE.
- FAULT (one cycle): done = 1, err = 1, reg_write = 0; no Avalon access issued -> IDLE.
- Alignment rules; w = captured word, k = addr[1:0]:
  - LB/LBU: byte w[8k+7:8k], sign- or zero-extended.
  - LH/LHU: halfword w[8k+15:8k] with k in {0,2}, sign- or zero-extended.
  - LW: w.
  - LWL: (w << 8*(3-k)) | (rt_old & ~(32'hFFFFFFFF << 8*(3-k))).
  - LWR: (w >> 8*k) | (rt_old & ~(32'hFFFFFFFF >> 8*k)).
- Latency:
  - start at cycle 0; avm_read high in cycle 1.
  - With zero wait states, reg_write/done in cycle 2.
  - Each waitrequest cycle adds 1.
  - FAULT: done in cycle 1.
- write_data and write_reg are driven only in WRITE; 0 elsewhere.
- Reset mid-operation: next state IDLE; avm_read = 0 from the following cycle. Any in-flight readdata is discarded; no reg_write or done is generated.

Optional Feature:
- Macro LOAD_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter (width = clog2(TIMEOUT_CYCLES+1)) increments each REQ cycle with waitrequest=1.
  - When it reaches TIMEOUT_CYCLES, the read is abandoned -> FAULT: avm_read drops, done = 1, err = 1, no write.
  - The counter clears on REQ entry.
- Not defined: REQ waits indefinitely; counter logic is absent.

Test Plan:
Memory word at 0x100 = 0x8899AABB; rt = 5 unless stated.
- LB, addr 0x101, no waits -> avm_address 0x100, reg_write in cycle 2, write_reg 5, write_data 0xFFFFFFAA, err 0.
- LBU 0x103 -> 0x00000088. LH 0x102 with 3 waitrequest cycles -> 0xFFFF8899, reg_write in cycle 5. LHU 0x100 -> 0x0000AABB.
- LWL 0x101, rt_old 0x11223344 -> 0xAABB3344. LWR 0x101, same rt_old -> 0x118899AA. LW 0x100, rt = 0 -> done = 1, reg_write = 0.
- LW 0x102 -> FAULT: done and err in cycle 1, avm_read never asserted. Opcode 101011 (SW) -> same FAULT response.
- Reset asserted during the 2nd waitrequest cycle -> avm_read 0 the next cycle; no reg_write/done; a new start afterwards completes normally.
- With LOAD_TIMEOUT_EN, TIMEOUT_CYCLES = 4, waitrequest held high -> done = 1, err = 1 after 4 stall cycles, avm_read deasserted, no write.

Source files
------------

// File: rtl/load_writeback_unit_if.sv
// Bus bundle for load_writeback_unit: control request, Avalon-MM read master and regfile write port.
// master = the load unit, slave = its environment (control FSM, memory, register file).
interface load_writeback_unit_if;
  logic        start;
  logic [31:0] instr;
  logic [31:0] addr;
  logic [31:0] rt_old;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, instr, addr, rt_old, avm_readdata, avm_waitrequest,
    output avm_address, avm_read, avm_byteenable, reg_write, write_reg, write_data, busy, done, err
  );

  modport slave (
    output start, instr, addr, rt_old, avm_readdata, avm_waitrequest,
    input  avm_address, avm_read, avm_byteenable, reg_write, write_reg, write_data, busy, done, err
  );
endinterface

// File: rtl/load_writeback_unit.sv
// Multicycle MIPS load engine: one Avalon read, then align/extend/merge and a one-cycle regfile write.
// Optional LOAD_TIMEOUT_EN aborts a read stalled for TIMEOUT_CYCLES waitrequest cycles.
module load_writeback_unit (
  input logic                   clk,
  input logic                   reset,
  load_writeback_unit_if.master bus
);
`ifdef LOAD_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255;
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] r_cnt;
`endif

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLwl = 6'b100010;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLwr = 6'b100110;

  typedef enum logic [1:0] {StIdle, StReq, StWrite, StFault} state_e;

  state_e      r_state;
  logic [5:0]  r_op;
  logic [4:0]  r_rt;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_rt_old;
  logic [31:0] r_avm_address;
  logic        r_avm_read;
  logic [3:0]  r_avm_byteenable;
  logic        r_reg_write;
  logic [4:0]  r_write_reg;
  logic [31:0] r_write_data;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_supported;
  logic        w_misaligned;
  logic [4:0]  w_shr_amt;
  logic [4:0]  w_shl_amt;
  logic [31:0] w_shr;
  logic [31:0] w_shl;
  logic [31:0] w_result;

  // Decode of the request presented with start.
  always_comb begin
    w_supported  = 1'b1;
    w_misaligned = 1'b0;
    case (bus.instr[31:26])
      OpLb, OpLbu, OpLwl, OpLwr: w_misaligned = 1'b0;
      OpLh, OpLhu:               w_misaligned = bus.addr[0];
      OpLw:                      w_misaligned = |bus.addr[1:0];
      default:                   w_supported  = 1'b0;
    endcase
  end

  // Alignment works straight off readdata so the result registers on the capture edge.
  always_comb begin
    w_shr_amt = {r_addr_lo, 3'b000};
    w_shl_amt = {2'd3 - r_addr_lo, 3'b000};
    w_shr     = bus.avm_readdata >> w_shr_amt;
    w_shl     = bus.avm_readdata << w_shl_amt;
    case (r_op)
      OpLb:    w_result = {{24{w_shr[7]}}, w_shr[7:0]};
      OpLbu:   w_result = {24'd0, w_shr[7:0]};
      OpLh:    w_result = {{16{w_shr[15]}}, w_shr[15:0]};
      OpLhu:   w_result = {16'd0, w_shr[15:0]};
      OpLw:    w_result = bus.avm_readdata;
      OpLwl:   w_result = w_shl | (r_rt_old & ~(32'hFFFF_FFFF << w_shl_amt));
      OpLwr:   w_result = w_shr | (r_rt_old & ~(32'hFFFF_FFFF >> w_shr_amt));
      default: w_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= StIdle;
      r_op             <= '0;
      r_rt             <= '0;
      r_addr_lo        <= '0;
      r_rt_old         <= '0;
      r_avm_address    <= '0;
      r_avm_read       <= 1'b0;
      r_avm_byteenable <= '0;
      r_reg_write      <= 1'b0;
      r_write_reg      <= '0;
      r_write_data     <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      r_cnt            <= '0;
`endif
    end else begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_op      <= bus.instr[31:26];
            r_rt      <= bus.instr[20:16];
            r_addr_lo <= bus.addr[1:0];
            r_rt_old  <= bus.rt_old;
            r_busy    <= 1'b1;
            if (!w_supported || w_misaligned) begin
              r_state <= StFault;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state          <= StReq;
              r_avm_address    <= {bus.addr[31:2], 2'b00};
              r_avm_read       <= 1'b1;
              r_avm_byteenable <= 4'b1111;
`ifdef LOAD_TIMEOUT_EN
              r_cnt            <= '0;
`endif
            end
          end
        end
        StReq: begin
          if (!bus.avm_waitrequest) begin
            r_state          <= StWrite;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_byteenable <= '0;
            r_reg_write      <= (r_rt != 5'd0);
            r_write_reg      <= r_rt;
            r_write_data     <= w_result;
            r_done           <= 1'b1;
          end
`ifdef LOAD_TIMEOUT_EN
          else if (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            r_state          <= StFault;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_byteenable <= '0;
            r_done           <= 1'b1;
            r_err            <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        StWrite, StFault: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.avm_address    = r_avm_address;
  assign bus.avm_read       = r_avm_read;
  assign bus.avm_byteenable = r_avm_byteenable;
  assign bus.reg_write      = r_reg_write;
  assign bus.write_reg      = r_write_reg;
  assign bus.write_data     = r_write_data;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.err            = r_err;
endmodule
